serial_word_receiver: RTL and testbench

//   Front end of the serial-to-parallel path: receives framed serial words on three async pins
//   (serial_clock, serial_frame, serial_data), synchronises and deserialises them MSB-first,
//   and writes each complete 24-bit word into the downstream 32x24 FIFO via a one-cycle write strobe.

---
 rtl/serial_rx_pkg.sv | 15 +
 rtl/bit_synchronizer.sv | 23 ++
 rtl/serial_word_receiver.sv | 190 +++++++++++++++++++
 tb/tb_serial_word_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial word receiver: FSM state encoding
// and the default word width / synchroniser depth.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_STORE    = 2'd2,
    ST_WAIT_END = 2'd3
  } rx_state_t;

  localparam int DEFAULT_WORD_WIDTH  = 24;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for one asynchronous input, with synchronous active-low clear.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic clear_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/serial_word_receiver.sv
// Synchronises framed serial words, deserialises them MSB-first and strobes each word into a FIFO.
// Optional WORD_PARITY_EN adds a trailing even-parity bit per word and a sticky parity_error output.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  serial_clock,
  input  logic                  serial_frame,
  input  logic                  serial_data,
  input  logic                  fifo_full,
  output logic                  write_data,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_error,
`ifdef WORD_PARITY_EN
  output logic                  parity_error,
`endif
  input  logic                  clear_errors,
  output rx_state_t             fsm_state
);

`ifdef WORD_PARITY_EN
  localparam int FRAME_BITS = WORD_WIDTH + 1;
`else
  localparam int FRAME_BITS = WORD_WIDTH;
`endif
  localparam int CNT_W = $clog2(WORD_WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

  logic sclk_s, frame_s, data_s;
  logic sclk_prev, sclk_rise;

  rx_state_t state, state_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [WORD_WIDTH-1:0] shreg;
  logic last_bit;
  logic parity_ok;

  logic cnt_clr, shift_en, do_write;
  logic set_overflow, set_frame_error;
`ifdef WORD_PARITY_EN
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_WIDTH);
  logic parity_bit;
  logic set_parity_error;
`endif

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clock(clock), .clear_n(reset_n), .async_in(serial_clock), .sync_out(sclk_s)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_frame (
    .clock(clock), .clear_n(reset_n), .async_in(serial_frame), .sync_out(frame_s)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clock(clock), .clear_n(reset_n), .async_in(serial_data), .sync_out(data_s)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sclk_prev <= 1'b0;
    end else begin
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign last_bit  = sclk_rise && (bit_cnt == LAST_IDX);

`ifdef WORD_PARITY_EN
  assign parity_ok = ~(^shreg ^ parity_bit);
`else
  assign parity_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a frame held high after STORE parks in WAIT_END until it drops.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (frame_s) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (last_bit)      state_next = ST_STORE;
        else if (!frame_s) state_next = ST_IDLE;
      end
      ST_STORE:    state_next = ST_WAIT_END;
      ST_WAIT_END: if (!frame_s) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Output logic. write_data is a one-cycle push strobe: the FIFO accepts it whenever
  // fifo_full was low in the STORE cycle; a full FIFO drops the word and sets overflow.
  always_comb begin
    cnt_clr         = 1'b0;
    shift_en        = 1'b0;
    do_write        = 1'b0;
    set_overflow    = 1'b0;
    set_frame_error = 1'b0;
`ifdef WORD_PARITY_EN
    set_parity_error = 1'b0;
`endif
    busy            = (state != ST_IDLE);
    fsm_state       = state;
    case (state)
      ST_IDLE:  cnt_clr = 1'b1;
      ST_SHIFT: begin
        shift_en        = sclk_rise;
        set_frame_error = !frame_s && !last_bit;
      end
      ST_STORE: begin
        do_write     = parity_ok && !fifo_full;
        set_overflow = parity_ok && fifo_full;
`ifdef WORD_PARITY_EN
        set_parity_error = !parity_ok;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef WORD_PARITY_EN
      if (bit_cnt < WORD_CNT) shreg <= {shreg[WORD_WIDTH-2:0], data_s};
`else
      shreg <= {shreg[WORD_WIDTH-2:0], data_s};
`endif
    end
  end

`ifdef WORD_PARITY_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      parity_bit <= 1'b0;
    end else if (shift_en && (bit_cnt == WORD_CNT)) begin
      parity_bit <= data_s;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      write_data <= 1'b0;
      data_out   <= '0;
    end else begin
      write_data <= do_write;
      if (do_write) data_out <= shreg;
    end
  end

  // Sticky flags: a set in the same cycle as clear_errors wins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      overflow    <= set_overflow | (overflow & ~clear_errors);
      frame_error <= set_frame_error | (frame_error & ~clear_errors);
    end
  end

`ifdef WORD_PARITY_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      parity_error <= 1'b0;
    end else begin
      parity_error <= set_parity_error | (parity_error & ~clear_errors);
    end
  end
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: framing, FIFO-full drop, short frames,
// over-long frames, mid-word reset and (with WORD_PARITY_EN) parity checking.
module tb_serial_word_receiver;
  import serial_rx_pkg::*;

  localparam int W = 24;
`ifdef WORD_PARITY_EN
  localparam int FB = W + 1;
`else
  localparam int FB = W;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic serial_clock = 1'b0;
  logic serial_frame = 1'b0;
  logic serial_data = 1'b0;
  logic fifo_full = 1'b0;
  logic clear_errors = 1'b0;
  logic write_data, busy, overflow, frame_error;
  logic [W-1:0] data_out;
  rx_state_t fsm_state;
`ifdef WORD_PARITY_EN
  logic parity_error;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int full_violations = 0;
  logic [W-1:0] got_q[$];
  int got_cycle[$];
  logic [W-1:0] exp_q[$];

  serial_word_receiver dut (
    .clock(clock), .reset_n(reset_n),
    .serial_clock(serial_clock), .serial_frame(serial_frame), .serial_data(serial_data),
    .fifo_full(fifo_full), .write_data(write_data), .data_out(data_out),
    .busy(busy), .overflow(overflow), .frame_error(frame_error),
`ifdef WORD_PARITY_EN
    .parity_error(parity_error),
`endif
    .clear_errors(clear_errors), .fsm_state(fsm_state)
  );

  // Clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  // Write monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (write_data === 1'b1) begin
      got_q.push_back(data_out);
      got_cycle.push_back(cycle);
      if (fifo_full) full_violations++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [31:0] mk(input logic [W-1:0] w);
`ifdef WORD_PARITY_EN
    mk = {7'd0, w, ^w};
`else
    mk = {8'd0, w};
`endif
  endfunction

  // Driver: sclk period 8 clocks, data changes while sclk is low
  task automatic send_bits(input logic [31:0] bits, input int nbits, input bit end_frame,
                           output int last_rise);
    serial_frame = 1'b1;
    wait_cycles(4);
    last_rise = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      serial_data = bits[i];
      wait_cycles(4);
      serial_clock = 1'b1;
      last_rise = cycle;
      wait_cycles(4);
      serial_clock = 1'b0;
    end
    wait_cycles(4);
    if (end_frame) begin
      serial_frame = 1'b0;
      wait_cycles(8);
    end
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    wait_cycles(1);
    clear_errors = 1'b0;
    wait_cycles(1);
  endtask

  task automatic reset_scoreboard();
    got_q.delete();
    got_cycle.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cycles(4);
    checks++; if (write_data !== 1'b0) begin failures++; $display("FAIL reset_write_data got=%b exp=0", write_data); end
    checks++; if (data_out !== 24'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=000000", data_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
    checks++; if (fsm_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    reset_n = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_single_word();
    int rise;
    reset_scoreboard();
    exp_q.push_back(24'hA5C3F0);
    send_bits(mk(24'hA5C3F0), FB, 1'b1, rise);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL single_data got=%h exp=%h", got_q[0], exp_q[0]); end
      checks++; if (got_cycle[0] - rise !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", got_cycle[0] - rise); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0 || frame_error !== 1'b0) begin failures++; $display("FAIL single_flags got=%b%b exp=00", overflow, frame_error); end
  endtask

  task automatic test_overflow();
    int rise;
    reset_scoreboard();
    fifo_full = 1'b1;
    send_bits(mk(24'h123456), FB, 1'b1, rise);
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL ovf_no_write got=%0d exp=0", got_q.size()); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    fifo_full = 1'b0;
    wait_cycles(3);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    pulse_clear();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_frame_error();
    int rise;
    reset_scoreboard();
    send_bits(32'h2B5, 10, 1'b0, rise);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_busy_mid got=%b exp=1", busy); end
    serial_frame = 1'b0;
    wait_cycles(8);
    checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", frame_error); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", busy); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL ferr_no_write got=%0d exp=0", got_q.size()); end
    exp_q.push_back(24'hFFFFFF);
    send_bits(mk(24'hFFFFFF), FB, 1'b1, rise);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL ferr_next_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL ferr_next_data got=%h exp=%h", got_q[0], exp_q[0]); end
    end
    checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", frame_error); end
    pulse_clear();
    checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", frame_error); end
  endtask

  task automatic test_long_frame();
    int rise;
    logic [31:0] v;
    reset_scoreboard();
    exp_q.push_back(24'hC0FFEE);
    v = (mk(24'hC0FFEE) << (30 - FB)) | 32'h15;
    send_bits(v, 30, 1'b1, rise);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL long_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL long_data got=%h exp=%h", got_q[0], exp_q[0]); end
    end
    checks++; if (frame_error !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL long_flags got=%b%b exp=00", frame_error, overflow); end
  endtask

  task automatic test_reset_mid_word();
    int rise;
    reset_scoreboard();
    send_bits(32'hABC, 12, 1'b0, rise);
    reset_n = 1'b0;
    serial_frame = 1'b0;
    wait_cycles(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 24'h0) begin failures++; $display("FAIL rst_mid_data_out got=%h exp=000000", data_out); end
    reset_n = 1'b1;
    wait_cycles(4);
    exp_q.push_back(24'h000001);
    send_bits(mk(24'h000001), FB, 1'b1, rise);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL rst_mid_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp_q[0]) begin failures++; $display("FAIL rst_mid_data got=%h exp=%h", got_q[0], exp_q[0]); end
    end
    checks++; if (frame_error !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b%b exp=00", frame_error, overflow); end
  endtask

`ifdef WORD_PARITY_EN
  task automatic test_parity();
    int rise;
    reset_scoreboard();
    send_bits({7'd0, 24'h000001, 1'b1}, 25, 1'b1, rise);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL par_good_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 24'h000001) begin failures++; $display("FAIL par_good_data got=%h exp=000001", got_q[0]); end
    end
    send_bits({7'd0, 24'h000001, 1'b0}, 25, 1'b1, rise);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL par_bad_count got=%0d exp=1", got_q.size()); end
    checks++; if (parity_error !== 1'b1) begin failures++; $display("FAIL par_bad_flag got=%b exp=1", parity_error); end
    pulse_clear();
    checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL par_clear got=%b exp=0", parity_error); end
    send_bits({8'd0, 24'h00F00F}, 24, 1'b1, rise);
    checks++; if (frame_error !== 1'b1) begin failures++; $display("FAIL par_short got=%b exp=1", frame_error); end
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL par_short_count got=%0d exp=1", got_q.size()); end
    pulse_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_frame_error();
    test_long_frame();
    test_reset_mid_word();
`ifdef WORD_PARITY_EN
    test_parity();
`endif
    checks++; if (full_violations !== 0) begin failures++; $display("FAIL write_while_full got=%0d exp=0", full_violations); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
